// File: rtl/wishbone_rr_arbiter.sv
// rtl/wishbone_rr_arbiter.sv - three-requester round-robin Wishbone arbiter with cyc lock, config gate and timeout abort
module wishbone_rr_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int SELECT_W = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  config_done,
  input  logic [2:0]            req_cyc,
  input  logic [2:0]            req_stb,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_adr,
  input  logic [3*DATA_W-1:0]   req_dat,
  input  logic [3*SELECT_W-1:0] req_sel,
  output logic [2:0]            req_ack,
  output logic [2:0]            req_err,
  output logic [DATA_W-1:0]     req_rdat,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_adr,
  output logic [DATA_W-1:0]     m_dat,
  output logic [SELECT_W-1:0]   m_sel,
  input  logic [DATA_W-1:0]     m_rdat,
  input  logic                  m_ack,
  output logic [2:0]            grant,
  output logic [7:0]            timeout_cnt
);

  // Abort fires on the edge where the watchdog would reach TIMEOUT, so the
  // err pulse lands exactly TIMEOUT cycles after the stall began.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic [1:0]  g_idx;
  logic [1:0]  nxt_ptr;
  logic        busy;
  logic [2:0]  elig;
  logic [2:0]  pick_oh;
  logic        pick_valid;
  logic [2:0]  cand;

  // Index of the currently granted requester (0 when no grant is held).
  always_comb begin
    g_idx = 2'd0;
    if (grant_q[1]) g_idx = 2'd1;
    if (grant_q[2]) g_idx = 2'd2;
  end

  assign nxt_ptr = (g_idx == 2'd2) ? 2'd0 : g_idx + 2'd1;
  assign busy    = (state_q == ST_BUSY);

  // Round-robin pick: first eligible requester at or after rr_ptr; only
  // requester 0 may win until configuration has completed.
  always_comb begin
    elig       = req_cyc & req_stb;
    pick_oh    = 3'b000;
    pick_valid = 1'b0;
    cand       = 3'd0;
    if (!config_done) elig = elig & 3'b001;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!pick_valid && elig[cand[1:0]]) begin
        pick_valid = 1'b1;
        pick_oh    = 3'b001 << cand[1:0];
      end
    end
  end

  // Slave-side mux: only a BUSY grant reaches the UART; IDLE and ABORT park at 0.
  always_comb begin
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    if (busy) begin
      m_cyc = req_cyc[g_idx];
      m_stb = req_stb[g_idx];
      m_we  = req_we[g_idx];
      m_adr = req_adr[g_idx*ADDR_W +: ADDR_W];
      m_dat = req_dat[g_idx*DATA_W +: DATA_W];
      m_sel = req_sel[g_idx*SELECT_W +: SELECT_W];
    end
  end

  // Requester-side returns: ack is a zero-cycle route to the owner, err marks the abort cycle.
  always_comb begin
    req_ack = busy ? (grant_q & {3{m_ack}}) : 3'b000;
    req_err = (state_q == ST_ABORT) ? grant_q : 3'b000;
  end

  assign req_rdat    = m_rdat;
  assign grant       = grant_q;
  assign timeout_cnt = tcnt_q;

  // Next-state logic for grant, pointer, watchdog and abort counter.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = 8'd0;
        if (pick_valid) begin
          grant_d = pick_oh;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req_cyc[g_idx]) begin
          // Owner released the bus: hand the pointer to its successor.
          grant_d  = 3'b000;
          rr_ptr_d = nxt_ptr;
          wdog_d   = 8'd0;
          state_d  = ST_IDLE;
        end else if (m_ack) begin
          wdog_d = 8'd0;
        end else if (req_stb[g_idx]) begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_q == TO_LAST) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        grant_d  = 3'b000;
        rr_ptr_d = nxt_ptr;
        wdog_d   = 8'd0;
        state_d  = ST_IDLE;
        if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
      end
      default: begin
        grant_d = 3'b000;
        wdog_d  = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers; reset drops the grant immediately, even mid-cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      grant_q  <= 3'b000;
      rr_ptr_q <= 2'd0;
      wdog_q   <= 8'd0;
      tcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
      tcnt_q   <= tcnt_d;
    end
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
# wishbone_rr_arbiter

Three-requester Wishbone arbiter that shares the single UART Wishbone slave port between the UART configuration engine (requester 0), the transfer handler engine (requester 1) and a spare/debug requester (requester 2). It sits in the UART gateway between the requesters and the UART IP. It grants round-robin, holds the grant for a whole bus cycle (`cyc` lock), restricts access to requester 0 until configuration completes, and aborts hung cycles with a timeout error.

## Interface
- `ADDR_W`, 5: Wishbone address width.
- `DATA_W`, 32: Wishbone data width.
- `SELECT_W`, 4: byte-select width.
- `TIMEOUT`, 255: maximum cycles a granted strobe waits for `ack` before abort (1..255).
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `config_done` in 1: while 0, only requester 0 is grantable.
- `req_cyc` in 3: per-requester `cyc`.
- `req_stb` in 3: per-requester `stb`.
- `req_we` in 3: per-requester write enable.
- `req_adr` in 3×ADDR_W: per-requester address, packed, requester i at bits [i*ADDR_W +: ADDR_W].
- `req_dat` in 3×DATA_W: per-requester write data, packed.
- `req_sel` in 3×SELECT_W: per-requester byte selects, packed.
- `req_ack` out 3: per-requester `ack`.
- `req_err` out 3: per-requester `err`, timeout abort.
- `req_rdat` out DATA_W: read data, broadcast to all requesters.
- `m_cyc`, `m_stb`, `m_we` out 1 each: to UART slave.
- `m_adr` out ADDR_W, `m_dat` out DATA_W, `m_sel` out SELECT_W: to UART slave.
- `m_rdat` in DATA_W: slave read data.
- `m_ack` in 1: slave acknowledge.
- `grant` out 3: one-hot registered grant, 0 when idle.
- `timeout_cnt` out 8: saturating count of timeout aborts since reset.

## Operation
- FSM states: IDLE, BUSY, ABORT. Reset state IDLE.
- **IDLE**
  - Eligible set = `req_cyc & req_stb`, masked to bit 0 when `config_done`=0.
  - If the eligible set is non-empty, pick the first eligible requester at or after `rr_ptr`, cyclically 0→1→2→0.
  - Register its one-hot in `grant` and go to BUSY.
- **BUSY**
  - `m_*` outputs are driven combinationally from the granted requester's inputs.
  - `req_ack[g]` = `m_ack`, and `req_ack` of every other requester is 0.
  - The watchdog counter clears on each `m_ack`. It increments while `m_stb`=1 and `m_ack`=0.
  - When the granted requester drops `cyc`: `grant`→0, `rr_ptr` = (g+1) mod 3, go to IDLE.
  - When the watchdog reaches TIMEOUT: go to ABORT.
- **ABORT** (exactly one cycle)
  - `m_cyc`=`m_stb`=0.
  - `req_err[g]`=1 for this cycle.
  - `timeout_cnt` increments, saturating at 255.
  - `grant`→0, `rr_ptr` = (g+1) mod 3, go to IDLE.
- The grant is never revoked mid-cycle, including when `config_done` falls while BUSY. The mask applies only at grant decision.
- `m_ack` arriving when not BUSY is ignored; no `req_ack` is produced.
- All `m_*` outputs are 0 whenever `grant`=0.
- Reset mid-cycle: the FSM goes to IDLE and `grant` goes to 0 immediately. The requester must re-issue.

## Timing
- Reset values:
  - `grant`=0, `rr_ptr`=0, watchdog=0, `timeout_cnt`=0.
  - All `m_*`, `req_ack` and `req_err` = 0.
  - `req_rdat` = `m_rdat` passthrough.
- Grant latency: a request sampled at edge N gives `grant` valid after edge N; `m_stb` is visible in cycle N+1.
- Ack path is combinational, zero-cycle: `m_ack` → `req_ack[g]`.
- The release cycle (`cyc` low) returns to IDLE at the next edge. Minimum gap between consecutive grants is one idle cycle.
- Abort occurs TIMEOUT cycles after the last ack or stb start. `req_err` is a single-cycle pulse.
- Simultaneous requests resolve by `rr_ptr`. A single requester re-requesting back-to-back is re-granted if alone.

## Test plan
- **Config gate.** `config_done`=0, requesters 1 and 2 hold `cyc`/`stb`.
  - Expected: `grant` stays 0 and `m_cyc`=0 for 50 cycles.
  - Then requester 0 requests: `grant`=3'b001 one cycle later.
- **Round-robin.** `config_done`=1, all three requesters issue single writes continuously (addr 0x03, data 0x83, sel 4'b0001). The slave acks 1 cycle after `stb`.
  - Expected grant order: 001, 010, 100, 001.
  - Each requester receives exactly one `req_ack` per grant.
- **Lock.** Requester 1 holds `cyc` across 4 reads (addr 0x05) while requester 0 requests.
  - Expected: `grant` stays 3'b010 throughout.
  - Expected: `req_rdat` equals `m_rdat` on each ack.
  - Requester 0 is granted 2 cycles after requester 1 drops `cyc`.
- **Timeout.** With TIMEOUT=8, the slave never acks requester 2.
  - Expected: `req_err[2]` pulses 8 cycles after `stb`, `m_cyc` drops, `timeout_cnt`=1.
  - The next grant goes to requester 0.
- **Stray ack.** `m_ack`=1 while `grant`=0.
  - Expected: all `req_ack`=0 and the FSM stays in IDLE.
- **Reset mid-cycle.** `rstn` asserted low while BUSY with requester 1.
  - Expected: `grant`=0 and `m_cyc`=0 immediately, without waiting for a clock.
  - After release, arbitration restarts with `rr_ptr`=0.
